// File: rtl/ifu_fetch_queue_if.sv
// Fetch-unit port bundle: backend redirect, icache/memory request/response and IDU delivery.
// Handshakes: a transfer happens in a cycle where valid and ready are both 1 at the rising edge;
// the sender holds valid only while it has something to send. Responses have no ready and are always taken.
interface ifu_fetch_queue_if #(
   parameter int ADDR_WIDTH = 32,
   parameter int INST_WIDTH = 32
);
   logic                  redirect_valid_i;
   logic [ADDR_WIDTH-1:0] redirect_pc_i;
   logic                  imem_req_valid_o;
   logic                  imem_req_ready_i;
   logic [ADDR_WIDTH-1:0] imem_req_addr_o;
   logic                  imem_rsp_valid_i;
   logic [INST_WIDTH-1:0] imem_rsp_data_i;
   logic                  idu_valid_o;
   logic                  idu_ready_i;
   logic [ADDR_WIDTH-1:0] idu_pc_o;
   logic [INST_WIDTH-1:0] idu_instr_o;

   modport master (
      input  redirect_valid_i, redirect_pc_i,
      output imem_req_valid_o, imem_req_addr_o,
      input  imem_req_ready_i, imem_rsp_valid_i, imem_rsp_data_i,
      output idu_valid_o, idu_pc_o, idu_instr_o,
      input  idu_ready_i
   );

   modport slave (
      output redirect_valid_i, redirect_pc_i,
      input  imem_req_valid_o, imem_req_addr_o,
      output imem_req_ready_i, imem_rsp_valid_i, imem_rsp_data_i,
      input  idu_valid_o, idu_pc_o, idu_instr_o,
      output idu_ready_i
   );
endinterface

// File: rtl/ifu_fetch_queue.sv
// Sequential instruction fetch with an FQ_DEPTH-entry in-order fetch queue and redirect flush.
// Optional macro IFU_FETCH_CNT_EN adds a 64-bit delivered-instruction counter output.
module ifu_fetch_queue #(
   parameter int                    ADDR_WIDTH = 32,
   parameter int                    INST_WIDTH = 32,
   parameter logic [ADDR_WIDTH-1:0] RESET_PC   = 32'h8000_0000,
   parameter int                    FQ_DEPTH   = 4
) (
   input  logic clk,
   input  logic rst_n,
   ifu_fetch_queue_if.master bus
`ifdef IFU_FETCH_CNT_EN
   ,
   output logic [63:0] ifu_fetch_cnt_o
`endif
);
   localparam int PTR_W = $clog2(FQ_DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam int STEP  = INST_WIDTH / 8;

   typedef logic [CNT_W-1:0] cnt_t;

   logic [ADDR_WIDTH-1:0] fetch_pc;
   logic [ADDR_WIDTH-1:0] pc_q    [FQ_DEPTH];
   logic [INST_WIDTH-1:0] instr_q [FQ_DEPTH];
   logic [FQ_DEPTH-1:0]   filled_q;
   logic [PTR_W-1:0]      alloc_ptr, fill_ptr, head_ptr;
   cnt_t                  alloc_cnt, drop_cnt, pend_cnt;

   logic [CNT_W:0]        credit_sum;
   logic                  req_valid, idu_valid;
   logic                  req_fire, idu_fire, rsp_drop, rsp_fill, rsp_outstanding;
   logic [ADDR_WIDTH-1:0] redirect_pc_aligned;

   // Credit counts stale in-flight responses too, so memory never sees more than FQ_DEPTH outstanding.
   assign credit_sum      = {1'b0, alloc_cnt} + {1'b0, drop_cnt};
   assign req_valid       = rst_n && !bus.redirect_valid_i && (credit_sum < (CNT_W+1)'(FQ_DEPTH));
   assign idu_valid       = rst_n && !bus.redirect_valid_i && filled_q[head_ptr];
   assign req_fire        = req_valid && bus.imem_req_ready_i;
   assign idu_fire        = idu_valid && bus.idu_ready_i;
   assign rsp_outstanding = (drop_cnt != '0) || (pend_cnt != '0);
   assign rsp_drop        = bus.imem_rsp_valid_i && (drop_cnt != '0);
   assign rsp_fill        = bus.imem_rsp_valid_i && (drop_cnt == '0) && (pend_cnt != '0);
   assign redirect_pc_aligned = bus.redirect_pc_i & ~ADDR_WIDTH'(STEP - 1);

   assign bus.imem_req_valid_o = req_valid;
   assign bus.imem_req_addr_o  = fetch_pc;
   assign bus.idu_valid_o      = idu_valid;
   assign bus.idu_pc_o         = pc_q[head_ptr];
   assign bus.idu_instr_o      = instr_q[head_ptr];

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         fetch_pc  <= RESET_PC;
         alloc_ptr <= '0;
         fill_ptr  <= '0;
         head_ptr  <= '0;
         alloc_cnt <= '0;
         drop_cnt  <= '0;
         pend_cnt  <= '0;
         filled_q  <= '0;
         for (int i = 0; i < FQ_DEPTH; i++) begin
            pc_q[i]    <= '0;
            instr_q[i] <= '0;
         end
      end else if (bus.redirect_valid_i) begin
         // Every unfilled allocation becomes a response to throw away; a same-cycle response is already one of them.
         fetch_pc  <= redirect_pc_aligned;
         alloc_ptr <= '0;
         fill_ptr  <= '0;
         head_ptr  <= '0;
         alloc_cnt <= '0;
         pend_cnt  <= '0;
         filled_q  <= '0;
         drop_cnt  <= drop_cnt + pend_cnt
                      - cnt_t'(bus.imem_rsp_valid_i && rsp_outstanding);
      end else begin
         if (req_fire) begin
            pc_q[alloc_ptr]     <= fetch_pc;
            filled_q[alloc_ptr] <= 1'b0;
            alloc_ptr           <= alloc_ptr + PTR_W'(1);
            fetch_pc            <= fetch_pc + ADDR_WIDTH'(STEP);
         end
         if (rsp_drop) begin
            drop_cnt <= drop_cnt - cnt_t'(1);
         end
         if (rsp_fill) begin
            instr_q[fill_ptr]  <= bus.imem_rsp_data_i;
            filled_q[fill_ptr] <= 1'b1;
            fill_ptr           <= fill_ptr + PTR_W'(1);
         end
         if (idu_fire) begin
            filled_q[head_ptr] <= 1'b0;
            head_ptr           <= head_ptr + PTR_W'(1);
         end
         alloc_cnt <= alloc_cnt + cnt_t'(req_fire) - cnt_t'(idu_fire);
         pend_cnt  <= pend_cnt + cnt_t'(req_fire) - cnt_t'(rsp_fill);
      end
   end

`ifdef IFU_FETCH_CNT_EN
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         ifu_fetch_cnt_o <= '0;
      end else if (idu_fire) begin
         ifu_fetch_cnt_o <= ifu_fetch_cnt_o + 64'd1;
      end
   end
`endif

`ifndef SYNTHESIS
   rsp_needs_outstanding: assert property (@(posedge clk) disable iff (!rst_n)
      bus.imem_rsp_valid_i |-> rsp_outstanding);
   outstanding_bounded: assert property (@(posedge clk) disable iff (!rst_n)
      ({1'b0, drop_cnt} + {1'b0, pend_cnt}) <= (CNT_W+1)'(FQ_DEPTH));
`endif
endmodule

// File: tb/tb_ifu_fetch_queue.sv
// Bench for ifu_fetch_queue: directed vector table, redirect sequence, and randomized traffic
// against a queue-based reference model with an in-order memory of configurable latency.
module tb_ifu_fetch_queue;
   localparam int          AW     = 32;
   localparam int          IW     = 32;
   localparam int          DEPTH  = 4;
   localparam logic [31:0] RST_PC = 32'h8000_0000;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   ifu_fetch_queue_if #(.ADDR_WIDTH(AW), .INST_WIDTH(IW)) bus ();
`ifdef IFU_FETCH_CNT_EN
   logic [63:0] fetch_cnt;
`endif

   ifu_fetch_queue #(.ADDR_WIDTH(AW), .INST_WIDTH(IW), .RESET_PC(RST_PC), .FQ_DEPTH(DEPTH)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
`ifdef IFU_FETCH_CNT_EN
      ,
      .ifu_fetch_cnt_o (fetch_cnt)
`endif
   );

   typedef struct {
      logic [31:0] pc;
      logic [31:0] instr;
      bit          filled;
   } fq_ent_t;

   typedef struct {
      logic [31:0] addr;
      int          due;
      bit          stale;
   } mem_ent_t;

   typedef struct {
      bit          reset_before;
      bit          idu_rdy;
      bit          req_rdy;
      bit          e_rv;
      logic [31:0] e_addr;
      bit          e_iv;
      logic [31:0] e_pc;
   } vec_t;

   fq_ent_t     fq[$];
   mem_ent_t    mem_q[$];
   vec_t        tbl[$];
   logic [31:0] m_pc;
   longint      m_deliv;
   int          cyc, lat;
   int          n_vec, n_err;

   // Per-cycle values captured in the sampling phase and consumed at the clock edge.
   bit          s_rsp_v, s_redir, s_req_fire_m, s_idu_fire_m, s_req_fire_dut;
   logic [31:0] s_req_addr, s_rpc;

   function automatic logic [31:0] data_of(input logic [31:0] a);
      return a ^ 32'h0f0f_0000;
   endfunction

   function automatic int stale_cnt();
      int n = 0;
      foreach (mem_q[i]) if (mem_q[i].stale) n++;
      return n;
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      bus.redirect_valid_i = 1'b0;
      bus.redirect_pc_i    = '0;
      bus.imem_req_ready_i = 1'b0;
      bus.imem_rsp_valid_i = 1'b0;
      bus.imem_rsp_data_i  = '0;
      bus.idu_ready_i      = 1'b0;
      @(posedge clk);
      @(negedge clk);
      #1;
      check("rst_req_valid", bus.imem_req_valid_o, 0);
      check("rst_req_addr", bus.imem_req_addr_o, RST_PC);
      check("rst_idu_valid", bus.idu_valid_o, 0);
      check("rst_idu_pc", bus.idu_pc_o, 0);
      check("rst_idu_instr", bus.idu_instr_o, 0);
`ifdef IFU_FETCH_CNT_EN
      check("rst_fetch_cnt", fetch_cnt, 0);
`endif
      @(negedge clk);
      rst_n = 1'b1;
      fq.delete();
      mem_q.delete();
      m_pc    = RST_PC;
      m_deliv = 0;
      cyc     = 0;
   endtask

   // Called at the falling edge: drive inputs, then compare DUT outputs with the model.
   task automatic cycle_begin(input bit idu_rdy, input bit req_rdy, input bit redir, input logic [31:0] rpc);
      bit exp_rv, exp_iv;
      s_rsp_v = (mem_q.size() > 0) && (mem_q[0].due <= cyc);
      bus.redirect_valid_i = redir;
      bus.redirect_pc_i    = rpc;
      bus.imem_req_ready_i = req_rdy;
      bus.idu_ready_i      = idu_rdy;
      bus.imem_rsp_valid_i = s_rsp_v;
      bus.imem_rsp_data_i  = s_rsp_v ? data_of(mem_q[0].addr) : 32'($urandom);
      exp_rv = !redir && ((fq.size() + stale_cnt()) < DEPTH);
      exp_iv = !redir && (fq.size() > 0) && fq[0].filled;
      #1;
      check("req_valid", bus.imem_req_valid_o, exp_rv);
      check("req_addr", bus.imem_req_addr_o, m_pc);
      check("idu_valid", bus.idu_valid_o, exp_iv);
      if (exp_iv) begin
         check("idu_pc", bus.idu_pc_o, fq[0].pc);
         check("idu_instr", bus.idu_instr_o, fq[0].instr);
      end
`ifdef IFU_FETCH_CNT_EN
      check("fetch_cnt", fetch_cnt, m_deliv);
`endif
      s_redir        = redir;
      s_rpc          = rpc;
      s_req_fire_m   = exp_rv && req_rdy;
      s_idu_fire_m   = exp_iv && idu_rdy;
      s_req_fire_dut = bus.imem_req_valid_o && req_rdy;
      s_req_addr     = bus.imem_req_addr_o;
   endtask

   task automatic cycle_end();
      mem_ent_t me, rsp_e;
      fq_ent_t  fe;
      bit       filled_one;
      @(posedge clk);
      if (s_rsp_v) rsp_e = mem_q.pop_front();
      if (s_redir) begin
         fq.delete();
         foreach (mem_q[i]) mem_q[i].stale = 1'b1;
         m_pc = s_rpc & ~32'h3;
      end else begin
         if (s_rsp_v && !rsp_e.stale) begin
            filled_one = 1'b0;
            foreach (fq[i]) begin
               if (!filled_one && !fq[i].filled) begin
                  fq[i].filled = 1'b1;
                  fq[i].instr  = data_of(rsp_e.addr);
                  filled_one   = 1'b1;
               end
            end
         end
         if (s_idu_fire_m) begin
            void'(fq.pop_front());
            m_deliv++;
         end
         if (s_req_fire_m) begin
            fe.pc = m_pc; fe.instr = '0; fe.filled = 1'b0;
            fq.push_back(fe);
            m_pc = m_pc + 32'd4;
         end
      end
      if (s_req_fire_dut) begin
         me.addr = s_req_addr; me.due = cyc + lat; me.stale = 1'b0;
         mem_q.push_back(me);
      end
      check("mem_outstanding_le_depth", (mem_q.size() <= DEPTH), 1);
      cyc++;
      @(negedge clk);
   endtask

   task automatic add_vec(input bit rb, input bit ir, input bit rr, input bit rv,
                          input logic [31:0] ad, input bit iv, input logic [31:0] pc);
      vec_t v;
      v.reset_before = rb; v.idu_rdy = ir; v.req_rdy = rr;
      v.e_rv = rv; v.e_addr = ad; v.e_iv = iv; v.e_pc = pc;
      tbl.push_back(v);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, expected finish before 200000");
      $fatal(1, "watchdog");
   end

   initial begin
      int  found_at;
      bit  redir;
      n_vec = 0;
      n_err = 0;
      lat   = 1;

      // Streaming at 1-cycle memory latency, then a stalled IDU filling the queue.
      add_vec(1, 1, 1, 1, 32'h8000_0000, 0, 32'h0);
      add_vec(0, 1, 1, 1, 32'h8000_0004, 0, 32'h0);
      add_vec(0, 1, 1, 1, 32'h8000_0008, 1, 32'h8000_0000);
      add_vec(0, 1, 1, 1, 32'h8000_000C, 1, 32'h8000_0004);
      add_vec(0, 1, 1, 1, 32'h8000_0010, 1, 32'h8000_0008);
      add_vec(1, 0, 1, 1, 32'h8000_0000, 0, 32'h0);
      add_vec(0, 0, 1, 1, 32'h8000_0004, 0, 32'h0);
      add_vec(0, 0, 1, 1, 32'h8000_0008, 1, 32'h8000_0000);
      add_vec(0, 0, 1, 1, 32'h8000_000C, 1, 32'h8000_0000);
      add_vec(0, 0, 1, 0, 32'h8000_0010, 1, 32'h8000_0000);
      add_vec(0, 0, 1, 0, 32'h8000_0010, 1, 32'h8000_0000);
      add_vec(0, 1, 1, 0, 32'h8000_0010, 1, 32'h8000_0000);
      add_vec(0, 1, 1, 1, 32'h8000_0010, 1, 32'h8000_0004);
      add_vec(0, 1, 1, 1, 32'h8000_0014, 1, 32'h8000_0008);
      add_vec(0, 1, 1, 1, 32'h8000_0018, 1, 32'h8000_000C);
      add_vec(0, 1, 1, 1, 32'h8000_001C, 1, 32'h8000_0010);

      foreach (tbl[i]) begin
         if (tbl[i].reset_before) do_reset();
         cycle_begin(tbl[i].idu_rdy, tbl[i].req_rdy, 1'b0, '0);
         check($sformatf("tbl%0d_req_valid", i), bus.imem_req_valid_o, tbl[i].e_rv);
         check($sformatf("tbl%0d_req_addr", i), bus.imem_req_addr_o, tbl[i].e_addr);
         check($sformatf("tbl%0d_idu_valid", i), bus.idu_valid_o, tbl[i].e_iv);
         if (tbl[i].e_iv) check($sformatf("tbl%0d_idu_pc", i), bus.idu_pc_o, tbl[i].e_pc);
         cycle_end();
      end

      // Latency 3: redirect lands with a response and a valid head, leaving two stale responses.
      do_reset();
      lat = 3;
      for (int i = 0; i < 4; i++) begin
         cycle_begin(1'b1, 1'b1, 1'b0, '0);
         cycle_end();
      end
      cycle_begin(1'b1, 1'b1, 1'b1, 32'h8000_1002);
      check("redir_rsp_same_cycle", bus.imem_rsp_valid_i, 1);
      check("redir_blocks_idu", bus.idu_valid_o, 0);
      check("redir_blocks_req", bus.imem_req_valid_o, 0);
      cycle_end();
      cycle_begin(1'b1, 1'b1, 1'b0, '0);
      check("redir_next_req_valid", bus.imem_req_valid_o, 1);
      check("redir_next_req_addr", bus.imem_req_addr_o, 32'h8000_1000);
      cycle_end();
      found_at = -1;
      for (int i = 0; i < 20 && found_at < 0; i++) begin
         cycle_begin(1'b1, 1'b1, 1'b0, '0);
         if (bus.idu_valid_o) begin
            found_at = i;
            check("redir_first_pc", bus.idu_pc_o, 32'h8000_1000);
            check("redir_first_instr", bus.idu_instr_o, data_of(32'h8000_1000));
         end
         cycle_end();
      end
      if (found_at < 0) begin
         n_vec++;
         n_err++;
         $display("FAIL redir_deliver_timeout: got no delivery in 20 cycles, expected one");
      end else begin
         check("redir_deliver_cycle", found_at, 3);
      end

      // Randomized traffic; each segment starts with a reset of both DUT and memory.
      for (int seg = 0; seg < 3; seg++) begin
         do_reset();
         case (seg)
            0:       lat = 1;
            1:       lat = 2;
            default: lat = 4;
         endcase
         for (int c = 0; c < 300; c++) begin
            redir = ($urandom_range(0, 24) == 0);
            cycle_begin(($urandom_range(0, 3) != 0),
                        (seg == 1) ? 1'($urandom_range(0, 1)) : 1'(c % 2 == 0),
                        redir, 32'($urandom));
            cycle_end();
         end
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule

// File: doc/ifu_fetch_queue.md
# ifu_fetch_queue

Parametrised instruction fetch unit that replaces the fixed free-running PC incrementer. It issues sequential fetch requests over a valid/ready memory port, tracks in-order outstanding responses in a FQ_DEPTH-entry fetch queue, and delivers pc/instruction pairs to the IDU through a valid/ready handshake. It accepts backend redirects, flushing the queue and discarding stale in-flight responses; it sits between the icache/memory and the IDU.

## Interface
- ADDR_WIDTH, 32, PC and fetch address width
- INST_WIDTH, 32, instruction width; PC step is INST_WIDTH/8
- RESET_PC, 32'h8000_0000, first fetch address after reset
- FQ_DEPTH, 4, queue entries and max outstanding requests; power of two, >= 2
- clk  input  1  clock, all state on rising edge
- rst_n  input  1  reset, synchronous, active-low
- redirect_valid_i  input  1  backend redirect request
- redirect_pc_i  input  ADDR_WIDTH  redirect target; low log2(INST_WIDTH/8) bits ignored (treated as 0)
- imem_req_valid_o  output  1  fetch request valid
- imem_req_ready_i  input  1  memory accepts request
- imem_req_addr_o  output  ADDR_WIDTH  fetch address
- imem_rsp_valid_i  input  1  response valid; always accepted, in request order
- imem_rsp_data_i  input  INST_WIDTH  fetched instruction
- idu_valid_o  output  1  head entry valid to IDU
- idu_ready_i  input  1  IDU accepts
- idu_pc_o  output  ADDR_WIDTH  pc of delivered instruction
- idu_instr_o  output  INST_WIDTH  delivered instruction

## Operation
- State: fetch_pc; queue entries {pc, instr, filled}; pointers alloc (tail), fill, head; counters alloc_cnt (entries allocated, 0..FQ_DEPTH), drop_cnt (stale responses to discard); all counters $clog2(FQ_DEPTH)+1 bits.
- Issue: imem_req_valid_o = !redirect_valid_i && (alloc_cnt + drop_cnt < FQ_DEPTH); imem_req_addr_o = fetch_pc.
- Request handshake: allocate tail entry with pc = fetch_pc, filled = 0; fetch_pc += INST_WIDTH/8 (wraps modulo 2^ADDR_WIDTH).
- Response: if drop_cnt > 0, discard, drop_cnt--; else write instr into fill entry, set filled, advance fill pointer.
- Response with nothing outstanding: protocol error, ignored; simulation assertion fires.
- Delivery: idu_valid_o = !redirect_valid_i && head.filled; on handshake free head entry, alloc_cnt--.
- Redirect (highest priority): no request or IDU handshake occurs that cycle; fetch_pc <= redirect_pc_i; all entries invalidated, pointers reset; drop_cnt <= drop_cnt + unfilled_allocated - (imem_rsp_valid_i ? 1 : 0); same-cycle response is discarded.
- Pointers wrap modulo FQ_DEPTH; full = alloc_cnt == FQ_DEPTH; empty head = alloc_cnt == 0.
- Total memory-outstanding requests never exceed FQ_DEPTH.

## Timing
- While rst_n low at a clock edge: fetch_pc = RESET_PC, counters/pointers 0, all filled = 0. Outputs: imem_req_valid_o 0 (no request while rst_n low), imem_req_addr_o RESET_PC, idu_valid_o 0, idu_pc_o 0, idu_instr_o 0.
- First cycle after release: imem_req_valid_o 1, addr RESET_PC.
- Response in cycle N -> idu_valid_o earliest cycle N+1 (no bypass).
- Redirect in cycle N -> request to redirect target earliest cycle N+1.
- Sustained 1 instr/cycle requires FQ_DEPTH >= memory latency + 2.
- Simultaneous alloc and free in one cycle: alloc_cnt unchanged; full queue with same-cycle IDU handshake still may not issue (credit check uses registered counts).
- Reset asserted mid-operation: all in-flight responses become invisible only if memory is reset too; drop_cnt cleared.

## Configuration
- IFU_FETCH_CNT_EN defined: adds output ifu_fetch_cnt_o, 64 bits, reset 0, increments on each IDU handshake, wraps at 2^64; redirects do not count.
- Undefined: port and counter absent; behaviour otherwise identical.

## Test plan
- Reset release, imem_req_ready_i=1, 1-cycle memory returning addr as data, idu_ready_i=1 -> idu_pc_o 0x80000000, 0x80000004, 0x80000008 on consecutive cycles after fill latency, one per cycle.
- idu_ready_i=0, memory always ready -> exactly 4 requests (0x80000000..0x8000000C), then imem_req_valid_o 0; raise ready -> four deliveries in order, fetching resumes at 0x80000010.
- Memory latency 3, redirect to 0x80001000 with 2 unfilled outstanding -> next 2 responses discarded; first delivered pc 0x80001000 with its data.
- Redirect same cycle as a response and as idu_valid_o=1 -> no IDU handshake, response discarded, drop_cnt = outstanding-1.
- imem_req_ready_i toggling every cycle, random idu_ready_i -> delivered pcs strictly sequential, no loss/duplication, never more than 4 outstanding.
- IFU_FETCH_CNT_EN defined, 10 deliveries plus 1 redirect -> ifu_fetch_cnt_o = 10.
